// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU arbiter: ALU op codes, FSM state
//            encoding and the EXEC-cycle counter load helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;

  // Counter wide enough for the largest supported MUL hold time (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Remaining EXEC cycles after the first one; any op other than MUL,
  // including undefined codes, finishes in a single EXEC cycle.
  function automatic logic [CNT_W-1:0] exec_cnt_load(input logic [3:0] op,
                                                     input int        mul_cycles);
    return (op == ALU_MUL) ? CNT_W'(mul_cycles - 1) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arb
// Purpose  : Two-requester grant selection for the shared ALU.
//            ALU_ARBITER_RR_EN defined   : round-robin, ties go to the
//                                          requester not granted last.
//            ALU_ARBITER_RR_EN undefined : fixed priority, requester 0 wins.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            req_i  - request vector {req1, req0}
//            upd_i  - a transfer happens this cycle; pointer follows grant
//            gnt_o  - one-hot grant (zero when nothing requested)
// Revision : 1.0  initial release
// ============================================================================
module alu_rr_arb
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

`ifdef ALU_ARBITER_RR_EN
  // 1 = requester 1 was granted last; resets to 1 so requester 0 wins the
  // first tie.
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= gnt_o[1];
    end
  end

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end
`else
  // No pointer in fixed-priority mode; these inputs only exist so both
  // builds share one port list.
  logic w_unused;
  assign w_unused = ^{clk, rst_n, upd_i};

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters. One
//            operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//            Grant policy is set by macro ALU_ARBITER_RR_EN (see alu_rr_arb).
// Params   : MUL_CYCLES - EXEC cycles a MUL holds the ALU (1..15)
// Ports    : clk, rst_n                 - clock, async active-low reset
//            reqN_valid/ready/a/b/op    - request channel of requester N
//            rspN_valid/ready/result/zero - response channel of requester N
//            alu_a, alu_b, alu_control  - registered drive to the ALU
//            alu_result, alu_zero       - combinational ALU outputs
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  state_t           state_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [3:0]       alu_ctrl_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_zero_q;
  logic [31:0]      rsp_result_q [2];

  logic [1:0]       w_gnt;
  logic [1:0]       w_ready;
  logic [1:0]       w_rsp_ready;
  logic             w_xfer;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic [3:0]       w_sel_op;

  alu_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1_valid, req0_valid}),
    .upd_i (w_xfer),
    .gnt_o (w_gnt)
  );

  // Grant only carries a bit for a valid requester, so ready implies valid
  // and any ready bit is a transfer. rst_n gates ready so it drops the
  // instant reset asserts, not at the next edge.
  assign w_ready     = (rst_n && (state_q == IDLE)) ? w_gnt : 2'b00;
  assign w_xfer      = |w_ready;
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  assign w_sel_a  = w_gnt[1] ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt[1] ? req1_b  : req0_b;
  assign w_sel_op = w_gnt[1] ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      cnt_q           <= '0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_ctrl_q      <= ALU_ADD;
      rsp_valid_q     <= 2'b00;
      rsp_zero_q      <= 2'b00;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_xfer) begin
            alu_a_q    <= w_sel_a;
            alu_b_q    <= w_sel_b;
            alu_ctrl_q <= w_sel_op;
            owner_q    <= w_gnt[1];
            cnt_q      <= exec_cnt_load(w_sel_op, MUL_CYCLES);
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_result_q[owner_q] <= alu_result;
            rsp_zero_q[owner_q]   <= alu_zero;
            rsp_valid_q[owner_q]  <= 1'b1;
            // Operands stay put; only the op code returns to its idle value.
            alu_ctrl_q            <= ALU_ADD;
            state_q               <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // Only the owner's ready matters; the other requester's is ignored.
          if (w_rsp_ready[owner_q]) begin
            rsp_valid_q[owner_q] <= 1'b0;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready  = w_ready[0];
  assign req1_ready  = w_ready[1];
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp1_zero   = rsp_zero_q[1];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Randomized self-checking bench for alu_arbiter. A reference
//            model derives expected ready/grant, response timing, ALU drive
//            and results from the block's rules; results go through a
//            per-requester scoreboard queue checked whenever the DUT
//            presents a response.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int MUL_CYC = 3;
`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero;
  logic        rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;

  alu_arbiter #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ADD, SUB, MUL (low 32 bits); anything else XORs.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a * b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_control, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    chk({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk({tag, "_rsp0_result"}, rsp0_result, 32'd0);
    chk({tag, "_rsp1_result"}, rsp1_result, 32'd0);
    chk({tag, "_rsp_zero"}, 32'({rsp1_zero, rsp0_zero}), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_control"}, 32'(alu_control), 32'd0);
  endtask

  // ---------------- reference model + scoreboard (monitor process) --------
  typedef struct packed {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic        m_busy, m_own, m_last;
  int unsigned m_xcyc, m_lat;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [1:0]  vld, exp_rdy, exp_rv;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      sb0.delete();
      sb1.delete();
    end else begin
      cyc++;
      // Which requester the block must accept this cycle, if any.
      vld     = {req1_valid, req0_valid};
      exp_rdy = 2'b00;
      if (!m_busy && vld != 2'b00) begin
        if (vld == 2'b11) exp_rdy = (RR && !m_last) ? 2'b10 : 2'b01;
        else              exp_rdy = vld;
      end
      chk("req_ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));

      exp_rv = 2'b00;
      if (m_busy && cyc >= m_xcyc + m_lat) exp_rv[m_own] = 1'b1;
      chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(exp_rv));

      if (m_busy && cyc > m_xcyc && cyc < m_xcyc + m_lat) begin
        chk("alu_control_exec", 32'(alu_control), 32'(m_op));
        chk("alu_a_exec", alu_a, m_a);
        chk("alu_b_exec", alu_b, m_b);
      end else if (!m_busy) begin
        chk("alu_control_idle", 32'(alu_control), 32'd0);
      end

      // Scoreboard: compare whenever the DUT presents a response.
      if (rsp0_valid) begin
        if (sb0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp0_unexpected: got valid expected none (cycle %0d)", cyc);
        end else begin
          chk("rsp0_result", rsp0_result, sb0[0].res);
          chk("rsp0_zero", 32'(rsp0_zero), 32'(sb0[0].z));
          if (rsp0_ready) void'(sb0.pop_front());
        end
      end
      if (rsp1_valid) begin
        if (sb1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp1_unexpected: got valid expected none (cycle %0d)", cyc);
        end else begin
          chk("rsp1_result", rsp1_result, sb1[0].res);
          chk("rsp1_zero", 32'(rsp1_zero), 32'(sb1[0].z));
          if (rsp1_ready) void'(sb1.pop_front());
        end
      end

      if (exp_rv != 2'b00 && (m_own ? rsp1_ready : rsp0_ready)) m_busy = 1'b0;

      if (exp_rdy != 2'b00) begin
        m_own  = exp_rdy[1];
        m_a    = m_own ? req1_a  : req0_a;
        m_b    = m_own ? req1_b  : req0_b;
        m_op   = m_own ? req1_op : req0_op;
        e.res  = alu_f(m_op, m_a, m_b);
        e.z    = (e.res == 32'd0);
        if (m_own) sb1.push_back(e);
        else       sb0.push_back(e);
        m_busy = 1'b1;
        m_xcyc = cyc;
        m_lat  = (m_op == 4'b0010) ? 32'(1 + MUL_CYC) : 32'd2;
        m_last = m_own;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic rand_req(output logic v, output logic [31:0] a, output logic [31:0] b, output logic [3:0] op);
    int unsigned k;
    v  = ($urandom_range(0, 99) < 70);
    k  = $urandom_range(0, 9);
    op = (k < 3) ? 4'b0000 : (k < 6) ? 4'b0001 : (k < 8) ? 4'b0010 : 4'($urandom_range(3, 15));
    a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
    b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
    if ($urandom_range(0, 4) == 0) b = a;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rand_req(req0_valid, req0_a, req0_b, req0_op);
      rand_req(req1_valid, req1_a, req1_b, req1_op);
      rsp0_ready = ($urandom_range(0, 99) < 55);
      rsp1_ready = ($urandom_range(0, 99) < 55);
    end
  endtask

  task automatic quiesce(input int n);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    random_phase(1500);
    quiesce(25);

    // MUL from requester 1, then reset in the middle of its EXEC window.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 4'b0010;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (req1_ready) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL mul_accept: got no req1_ready expected ready within 10 cycles");
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    random_phase(300);
    quiesce(30);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
